pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Parametrised successor to the dedicated jump/branch PC adder: owns the program counter register, computes sequential, jump, conditional-branch (beq/bne) and call/return targets, and commits the selected next PC each clock.
- Adds stall hold, a one-cycle flush pulse after every taken redirect, and a small return-address stack (RAS) with sticky overflow/underflow flags.
- Sits between instruction memory address generation and the control unit / ALU ZERO flag.

Parameters:
PC_W, 32, program counter width in bits
OFFSET_W, 8, width of signed word offset from the instruction
WORD_BYTES, 4, bytes per instruction; sequential step and offset scale
RESET_PC, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  synchronous, active-low reset
STALL  input  1  1 = hold PC, RAS and flags this cycle
BR_TYPE  input  3  000 none, 001 jump, 010 beq, 011 bne, 100 call, 101 return; 110/111 treated as none
ZERO  input  1  ALU zero flag for the current instruction
OFFSET  input  OFFSET_W  signed word offset, two's complement
PC  output  PC_W  current program counter (registered)
PC_PLUS  output  PC_W  PC + WORD_BYTES (combinational)
TAKEN  output  1  current instruction redirects (combinational)
FLUSH  output  1  registered; high one cycle after a committed redirect
RAS_COUNT  output  clog2(RAS_DEPTH)+1  valid RAS entries
RAS_OVF  output  1  sticky: push occurred while full
RAS_UNF  output  1  sticky: pop occurred while empty

Behaviour:
- Reset (RESET=0 at CLK edge): PC=RESET_PC, FLUSH=0, RAS_COUNT=0, RAS_OVF=0, RAS_UNF=0, RAS pointer=0. Reset overrides STALL and BR_TYPE. Reset mid-redirect discards the redirect; no FLUSH follows.
- Arithmetic, all modulo 2^PC_W with silent wrap:
  - PC_PLUS = PC + WORD_BYTES.
  - BRANCH_TGT = PC_PLUS + sext(OFFSET) * WORD_BYTES.
- TAKEN and NEXT_PC by BR_TYPE:
  - jump: TAKEN=1, NEXT_PC=BRANCH_TGT.
  - beq: TAKEN=ZERO. bne: TAKEN=!ZERO. NEXT_PC=BRANCH_TGT if taken, else PC_PLUS.
  - call: TAKEN=1, NEXT_PC=BRANCH_TGT; commit pushes PC_PLUS.
  - return: if RAS_COUNT>0, TAKEN=1 and NEXT_PC=top entry; commit pops. If empty, TAKEN=0, NEXT_PC=PC_PLUS, and commit sets RAS_UNF.
  - none/reserved: TAKEN=0, NEXT_PC=PC_PLUS.
- Commit: on a CLK edge with RESET=1 and STALL=0, PC<=NEXT_PC, FLUSH<=TAKEN, RAS updated.
- Stall: on a CLK edge with STALL=1, PC, RAS, RAS_COUNT and flags hold; FLUSH<=0. TAKEN still reflects the inputs combinationally. A redirect is committed only on the non-stalled edge.
- RAS is circular, with one pointer to the next free slot:
  - Push when full: overwrite the oldest entry, RAS_COUNT stays RAS_DEPTH, RAS_OVF<=1.
  - Pop decrements the pointer and RAS_COUNT.
  - Push and pop are never simultaneous (one BR_TYPE per cycle).
- Flag clearing: RAS_OVF and RAS_UNF clear only on reset.
- Timing:
  - Latency from inputs to PC is one edge.
  - FLUSH asserts in the cycle after the commit edge, for exactly one cycle.
  - Back-to-back taken redirects keep FLUSH high continuously.

Decomposition:
- Shared package: BR_TYPE encodings (BR_NONE, BR_JUMP, BR_BEQ, BR_BNE, BR_CALL, BR_RET) and the WORD_BYTES default; the control unit reuses them.
- One sub-module, ras_stack (RAS_DEPTH, PC_W): push/pop/top/count/ovf/unf with hold on an enable input.
- Target arithmetic and select logic stay in pc_next_unit.

Test Plan:
- Reset with RESET_PC=0, then 3 cycles BR_TYPE=none -> PC 0,4,8,12; FLUSH=0 throughout.
- At PC=8: beq, ZERO=1, OFFSET=-2 -> TAKEN=1, next PC=4, FLUSH=1 one cycle. Repeat with ZERO=0 -> PC=12, FLUSH=0. bne with ZERO=0, OFFSET=3 -> PC=24.
- At PC=0x10: call, OFFSET=4 -> PC=0x24, RAS_COUNT=1. Then return -> PC=0x14, RAS_COUNT=0, FLUSH pulses after each.
- 5 calls with RAS_DEPTH=4 -> RAS_OVF=1, RAS_COUNT=4. Then 4 returns yield the last 4 return addresses in LIFO order; 5th return -> TAKEN=0, PC+=4, RAS_UNF=1.
- At PC=0x20: jump, OFFSET=1, STALL=1 for 2 cycles -> PC holds 0x20, TAKEN=1, FLUSH=0. Release STALL -> PC=0x28, then FLUSH=1.
- PC=0xFFFFFFFC, none -> PC=0 (wrap). Jump issued with RESET=0 on the same edge -> PC=RESET_PC, FLUSH=0, flags cleared.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// pc_next_unit_pkg: branch-type encodings and shared defaults for PC sequencing
package pc_next_unit_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JUMP = 3'b001,
        BR_BEQ  = 3'b010,
        BR_BNE  = 3'b011,
        BR_CALL = 3'b100,
        BR_RET  = 3'b101
    } br_type_e;

    localparam int WORD_BYTES_DEF = 4;

endpackage

// File: rtl/pc_next_unit_ras_stack.sv
// ras_stack: circular return-address stack with sticky overflow/underflow flags
module ras_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [PC_W-1:0]             data_i,
    output logic [PC_W-1:0]             top_o,
    output logic [$clog2(RAS_DEPTH):0]  count_o,
    output logic                        ovf_o,
    output logic                        unf_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, top_idx;
    logic [PW:0]     cnt_q, cnt_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            empty, full, do_push, do_pop;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == FULL;
    assign do_push = en_i && push_i;
    assign do_pop  = en_i && pop_i && !empty;
    assign top_idx = ptr_q - 1'b1;
    assign top_o   = mem_q[top_idx];
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    // A push when full still advances the pointer so the oldest entry is overwritten
    always_comb begin
        ptr_d = do_push ? ptr_q + 1'b1 : do_pop ? ptr_q - 1'b1 : ptr_q;
        cnt_d = (do_push && !full) ? cnt_q + 1'b1 : do_pop ? cnt_q - 1'b1 : cnt_q;
        ovf_d = ovf_q | (do_push && full);
        unf_d = unf_q | (en_i && pop_i && empty);
    end

    // Pointer, occupancy and sticky flags
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; contents are meaningless until counted valid, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[ptr_q] <= data_i;
    end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter register with branch/jump/call/return targeting and flush
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter int              OFFSET_W   = 8,
    parameter int              WORD_BYTES = WORD_BYTES_DEF,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        STALL,
    input  logic [2:0]                  BR_TYPE,
    input  logic                        ZERO,
    input  logic [OFFSET_W-1:0]         OFFSET,
    output logic [PC_W-1:0]             PC,
    output logic [PC_W-1:0]             PC_PLUS,
    output logic                        TAKEN,
    output logic                        FLUSH,
    output logic [$clog2(RAS_DEPTH):0]  RAS_COUNT,
    output logic                        RAS_OVF,
    output logic                        RAS_UNF
);
    logic [PC_W-1:0] pc_q, pc_d, off_ext, branch_tgt, ras_top;
    logic            flush_q, flush_d, taken, push, pop;

    assign off_ext    = {{(PC_W-OFFSET_W){OFFSET[OFFSET_W-1]}}, OFFSET};
    assign PC_PLUS    = pc_q + PC_W'(WORD_BYTES);
    assign branch_tgt = PC_PLUS + off_ext * PC_W'(WORD_BYTES);
    assign PC         = pc_q;
    assign TAKEN      = taken;
    assign FLUSH      = flush_q;

    // Decode the branch type into a redirect decision, RAS action and next PC
    always_comb begin
        taken = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        case (BR_TYPE)
            BR_JUMP: taken = 1'b1;
            BR_BEQ:  taken = ZERO;
            BR_BNE:  taken = !ZERO;
            BR_CALL: begin
                taken = 1'b1;
                push  = 1'b1;
            end
            BR_RET: begin
                taken = RAS_COUNT != '0;
                pop   = 1'b1;
            end
            default: taken = 1'b0;
        endcase
        pc_d    = !taken ? PC_PLUS : (BR_TYPE == BR_RET) ? ras_top : branch_tgt;
        flush_d = !STALL && taken;
    end

    // PC commits only on non-stalled edges; flush follows a committed redirect
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= STALL ? pc_q : pc_d;
            flush_q <= flush_d;
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .en_i    (!STALL),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (PC_PLUS),
        .top_o   (ras_top),
        .count_o (RAS_COUNT),
        .ovf_o   (RAS_OVF),
        .unf_o   (RAS_UNF)
    );

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed vectors with a queue-based scoreboard for pc_next_unit
module tb_pc_next_unit;
    import pc_next_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, STALL, ZERO;
    logic [2:0]  BR_TYPE;
    logic [7:0]  OFFSET;
    logic [31:0] PC, PC_PLUS;
    logic        TAKEN, FLUSH, RAS_OVF, RAS_UNF;
    logic [2:0]  RAS_COUNT;

    typedef struct {
        logic        ct;
        logic        et;
        logic [31:0] pc;
        logic        f;
        logic [2:0]  c;
        logic        o;
        logic        u;
        int          id;
    } item_t;

    item_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    n     = 0;

    pc_next_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .STALL     (STALL),
        .BR_TYPE   (BR_TYPE),
        .ZERO      (ZERO),
        .OFFSET    (OFFSET),
        .PC        (PC),
        .PC_PLUS   (PC_PLUS),
        .TAKEN     (TAKEN),
        .FLUSH     (FLUSH),
        .RAS_COUNT (RAS_COUNT),
        .RAS_OVF   (RAS_OVF),
        .RAS_UNF   (RAS_UNF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Apply one vector after a posedge and queue its expected outcome
    task automatic step(input logic rst, input logic stall, input logic [2:0] br, input logic z,
                        input logic [7:0] off, input logic ct, input logic et, input logic [31:0] epc,
                        input logic ef, input logic [2:0] ec, input logic eo, input logic eu);
        item_t it;
        RESET = rst; STALL = stall; BR_TYPE = br; ZERO = z; OFFSET = off;
        it.ct = ct; it.et = et; it.pc = epc; it.f = ef; it.c = ec; it.o = eo; it.u = eu; it.id = n++;
        q.push_back(it);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: TAKEN mid-cycle, registered state just after the commit edge
    initial begin
        item_t it;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                it = q.pop_front();
                if (it.ct) chk("TAKEN", it.id, 32'(TAKEN), 32'(it.et));
                @(posedge CLK);
                #3;
                chk("PC", it.id, PC, it.pc);
                chk("PC_PLUS", it.id, PC_PLUS, it.pc + 32'd4);
                chk("FLUSH", it.id, 32'(FLUSH), 32'(it.f));
                chk("RAS_COUNT", it.id, 32'(RAS_COUNT), 32'(it.c));
                chk("RAS_OVF", it.id, 32'(RAS_OVF), 32'(it.o));
                chk("RAS_UNF", it.id, 32'(RAS_UNF), 32'(it.u));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; STALL = 1'b0; BR_TYPE = BR_NONE; ZERO = 1'b0; OFFSET = '0;
        @(posedge CLK);
        #1;
        //     rst  stl  br       z  off    ct et  pc            f  c  o  u
        step(0, 0, BR_NONE, 0, 8'd0,   0, 0, 32'h0,        0, 0, 0, 0);
        step(1, 0, BR_NONE, 0, 8'd0,   1, 0, 32'h4,        0, 0, 0, 0);
        step(1, 0, BR_NONE, 0, 8'd0,   1, 0, 32'h8,        0, 0, 0, 0);
        step(1, 0, BR_BEQ,  1, -8'sd2, 1, 1, 32'h4,        1, 0, 0, 0);
        step(1, 0, BR_NONE, 0, 8'd0,   1, 0, 32'h8,        0, 0, 0, 0);
        step(1, 0, BR_BEQ,  0, -8'sd2, 1, 0, 32'hC,        0, 0, 0, 0);
        step(1, 0, BR_JUMP, 0, -8'sd2, 1, 1, 32'h8,        1, 0, 0, 0);
        step(1, 0, BR_BNE,  0, 8'd3,   1, 1, 32'h18,       1, 0, 0, 0);
        step(1, 0, BR_BNE,  1, 8'd3,   1, 0, 32'h1C,       0, 0, 0, 0);
        step(1, 0, 3'b110,  0, 8'd3,   1, 0, 32'h20,       0, 0, 0, 0);
        step(1, 0, BR_JUMP, 0, -8'sd5, 1, 1, 32'h10,       1, 0, 0, 0);
        step(1, 0, BR_CALL, 0, 8'd4,   1, 1, 32'h24,       1, 1, 0, 0);
        step(1, 0, BR_RET,  0, 8'd0,   1, 1, 32'h14,       1, 0, 0, 0);
        step(1, 0, BR_NONE, 0, 8'd0,   1, 0, 32'h18,       0, 0, 0, 0);
        step(1, 0, BR_CALL, 0, 8'd0,   1, 1, 32'h1C,       1, 1, 0, 0);
        step(1, 0, BR_CALL, 0, 8'd0,   1, 1, 32'h20,       1, 2, 0, 0);
        step(1, 0, BR_CALL, 0, 8'd0,   1, 1, 32'h24,       1, 3, 0, 0);
        step(1, 0, BR_CALL, 0, 8'd0,   1, 1, 32'h28,       1, 4, 0, 0);
        step(1, 0, BR_CALL, 0, 8'd0,   1, 1, 32'h2C,       1, 4, 1, 0);
        step(1, 0, BR_RET,  0, 8'd0,   1, 1, 32'h2C,       1, 3, 1, 0);
        step(1, 0, BR_RET,  0, 8'd0,   1, 1, 32'h28,       1, 2, 1, 0);
        step(1, 0, BR_RET,  0, 8'd0,   1, 1, 32'h24,       1, 1, 1, 0);
        step(1, 0, BR_RET,  0, 8'd0,   1, 1, 32'h20,       1, 0, 1, 0);
        step(1, 0, BR_RET,  0, 8'd0,   1, 0, 32'h24,       0, 0, 1, 1);
        step(1, 0, BR_JUMP, 0, -8'sd2, 1, 1, 32'h20,       1, 0, 1, 1);
        step(1, 1, BR_JUMP, 0, 8'd1,   1, 1, 32'h20,       0, 0, 1, 1);
        step(1, 1, BR_JUMP, 0, 8'd1,   1, 1, 32'h20,       0, 0, 1, 1);
        step(1, 0, BR_JUMP, 0, 8'd1,   1, 1, 32'h28,       1, 0, 1, 1);
        step(1, 0, BR_NONE, 0, 8'd0,   1, 0, 32'h2C,       0, 0, 1, 1);
        step(1, 1, BR_CALL, 0, 8'd0,   1, 1, 32'h2C,       0, 0, 1, 1);
        step(1, 0, BR_JUMP, 0, -8'sd12,1, 1, 32'h0,        1, 0, 1, 1);
        step(1, 0, BR_JUMP, 0, -8'sd2, 1, 1, 32'hFFFFFFFC, 1, 0, 1, 1);
        step(1, 0, BR_NONE, 0, 8'd0,   1, 0, 32'h0,        0, 0, 1, 1);
        step(1, 0, BR_CALL, 0, 8'd1,   1, 1, 32'h8,        1, 1, 1, 1);
        step(0, 0, BR_JUMP, 0, 8'd5,   1, 1, 32'h0,        0, 0, 0, 0);
        step(1, 0, BR_NONE, 0, 8'd0,   1, 0, 32'h4,        0, 0, 0, 0);
        step(1, 0, BR_RET,  0, 8'd0,   1, 0, 32'h8,        0, 0, 0, 1);
        RESET = 1'b1; STALL = 1'b1; BR_TYPE = BR_NONE;
        repeat (6) @(posedge CLK);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
